// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : alu_pkg
//  Purpose   : Shared op encodings, FSM state type and default datapath width
//              for the execute-stage ALU.
//  Revision  : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_XLEN = 32;

    // funct3-coded operation select
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SRL  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_serial_shifter.sv
`default_nettype none
// ============================================================================
//  Module    : alu_serial_shifter
//  Purpose   : Bit-serial shifter. A start pulse loads the operand, amount,
//              direction and fill mode; one bit is shifted per cycle. done is
//              high during the cycle whose edge performs the final shift, with
//              data_out already showing the post-shift value.
//  Revision  : 1.0 - initial release
// ============================================================================
module alu_serial_shifter #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [XLEN-1:0]    data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir_left,
    input  logic               arith,
    output logic               done,
    output logic [XLEN-1:0]    data_out
);

    logic [XLEN-1:0]    r_shreg;
    logic [SHAMT_W-1:0] r_count;
    logic               r_left;
    logic               r_arith;
    logic [XLEN-1:0]    w_shifted;
    logic               w_fill;

    // One-bit step: left fills zero, right fills sign bit only for arithmetic
    always_comb begin
        w_fill    = r_arith & r_shreg[XLEN-1];
        w_shifted = r_left ? {r_shreg[XLEN-2:0], 1'b0}
                           : {w_fill, r_shreg[XLEN-1:1]};
    end

    // Load on start, then shift and count down until the counter empties
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg <= '0;
            r_count <= '0;
            r_left  <= 1'b0;
            r_arith <= 1'b0;
        end else if (start) begin
            r_shreg <= data_in;
            r_count <= shamt;
            r_left  <= dir_left;
            r_arith <= arith;
        end else if (r_count != '0) begin
            r_shreg <= w_shifted;
            r_count <= r_count - SHAMT_W'(1);
        end
    end

    assign done     = (r_count == SHAMT_W'(1));
    assign data_out = w_shifted;

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module    : alu_exec_unit
//  Purpose   : Execute-stage ALU with valid/ready on both sides. Arithmetic,
//              logic and compare complete in one cycle; shifts run through the
//              bit-serial shifter. Result and zero are held until taken.
//  Revision  : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = ALU_XLEN,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      ALUopr,
    input  logic            SUBorSRA,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    state_t             r_state;
    state_t             w_state_next;
    logic [XLEN-1:0]    r_result;
    logic               r_zero;
    logic [XLEN-1:0]    w_alu_result;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_accept;
    logic               w_is_shift;
    logic               w_serial;
    logic               w_sh_done;
    logic [XLEN-1:0]    w_sh_data;

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = (r_state == ST_DONE);
    assign result     = r_result;
    assign zero       = r_zero;
    assign w_accept   = in_valid & in_ready;
    assign w_shamt    = opB[SHAMT_W-1:0];
    assign w_is_shift = (ALUopr == OP_SLL) || (ALUopr == OP_SRL);
    // Only a non-zero shift amount needs the serial path
    assign w_serial   = w_is_shift && (w_shamt != '0);

    // Single-cycle datapath; shift ops pass opA through for the zero-amount case
    always_comb begin
        w_alu_result = opA;
        case (ALUopr)
            OP_ADD:  w_alu_result = SUBorSRA ? (opA - opB) : (opA + opB);
            OP_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(opA) < $signed(opB))};
            OP_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, (opA < opB)};
            OP_XOR:  w_alu_result = opA ^ opB;
            OP_OR:   w_alu_result = opA | opB;
            OP_AND:  w_alu_result = opA & opB;
            default: w_alu_result = opA;
        endcase
    end

    alu_serial_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .start    (w_accept & w_serial),
        .data_in  (opA),
        .shamt    (w_shamt),
        .dir_left (ALUopr == OP_SLL),
        .arith    (SUBorSRA),
        .done     (w_sh_done),
        .data_out (w_sh_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: accept only in IDLE, release DONE on the output handshake
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_serial ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (w_sh_done) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Result/zero capture: at accept for single-cycle ops, at final shift otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_accept && !w_serial) begin
            r_result <= w_alu_result;
            r_zero   <= (w_alu_result == '0);
        end else if ((r_state == ST_SHIFT) && w_sh_done) begin
            r_result <= w_sh_data;
            r_zero   <= (w_sh_data == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module    : tb_alu_exec_unit
//  Purpose   : Scoreboard bench for alu_exec_unit.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam logic [2:0] T_ADD = 3'b000, T_SLL = 3'b001, T_SLT = 3'b010,
                           T_SLTU = 3'b011, T_XOR = 3'b100, T_SRL = 3'b101,
                           T_OR = 3'b110, T_AND = 3'b111;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  ALUopr;
    logic        SUBorSRA;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    typedef struct {
        logic [31:0] res;
        logic        zf;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   seen   = 1'b0;

    alu_exec_unit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUopr    (ALUopr),
        .SUBorSRA  (SUBorSRA),
        .opA       (opA),
        .opB       (opB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic sra,
                                          input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            T_ADD:   return sra ? a - b : a + b;
            T_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            T_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            T_XOR:   return a ^ b;
            T_OR:    return a | b;
            T_AND:   return a & b;
            T_SLL:   return a << sh;
            default: return sra ? 32'($signed(a) >>> sh) : (a >> sh);
        endcase
    endfunction

    // Present one operation at a negedge, push its expectation, wait for accept
    task automatic send(input logic [2:0] op, input logic sra,
                        input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bit   ok;
        ALUopr   = op;
        SUBorSRA = sra;
        opA      = a;
        opB      = b;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                e.res     = model(op, sra, a, b);
                e.zf      = (e.res == 32'd0);
                e.acc_cyc = cyc + 1;
                e.lat     = (op == T_SLL || op == T_SRL) ? int'(b[4:0]) : 0;
                sb.push_back(e);
                ok = 1'b1;
                @(posedge clk);
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard consumer: latency on first sight of out_valid, data on handshake
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                check_eq("spurious_valid", 32'd1, 32'd0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    check_eq("latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
                end
                if (out_ready) begin
                    check_eq("result", result, sb[0].res);
                    check_eq("zero", {31'd0, zero}, {31'd0, sb[0].zf});
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        ALUopr    = 3'b000;
        SUBorSRA  = 1'b0;
        opA       = '0;
        opB       = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check_eq("rst_result",    result,             32'd0);
        check_eq("rst_zero",      {31'd0, zero},      32'd0);
        reset = 1'b0;
        @(negedge clk);

        send(T_ADD,  1'b0, 32'd5,          32'd7);
        send(T_ADD,  1'b1, 32'h1234,       32'h1234);
        send(T_SLT,  1'b0, 32'hFFFF_FFFF,  32'd1);
        send(T_SLTU, 1'b0, 32'hFFFF_FFFF,  32'd1);
        send(T_SRL,  1'b1, 32'h8000_0000,  32'd4);
        send(T_SRL,  1'b0, 32'h8000_0000,  32'd4);
        send(T_XOR,  1'b1, 32'hF0F0_1234,  32'h0FF0_4321);
        send(T_OR,   1'b0, 32'h1200_0034,  32'h0056_7800);
        send(T_AND,  1'b1, 32'hDEAD_BEEF,  32'h0F0F_0F0F);
        send(T_SLL,  1'b1, 32'h0000_0003,  32'hFFFF_FFE2);
        send(T_ADD,  1'b0, 32'hFFFF_FFFF,  32'd1);
        send(T_SRL,  1'b1, 32'h7000_0000,  32'd31);
        for (int i = 0; i < 12; i++) begin
            send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
        wait_drain();

        // Held result: consumer stalls, a new request must not be taken
        out_ready = 1'b0;
        send(T_SLL, 1'b0, 32'h0000_00A5, 32'h0000_0100);
        ALUopr = T_ADD; opA = 32'd9; opB = 32'd9; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("hold_valid",    {31'd0, out_valid}, 32'd1);
            check_eq("hold_in_ready", {31'd0, in_ready},  32'd0);
            check_eq("hold_result",   result,             32'h0000_00A5);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Reset in the middle of a long shift drops the operation
        send(T_SLL, 1'b0, 32'h0000_0001, 32'd31);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        seen = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_valid",  {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_ready",  {31'd0, in_ready},  32'd1);
        check_eq("mid_rst_result", result,             32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        send(T_ADD, 1'b0, 32'd1, 32'd1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
